// File: rtl/addsub_multicycle_if.sv
// Operand/result bundle for addsub_multicycle: START/SUB/A/B in, BUSY/DONE/S/V/COUT out.
// The master side issues operations; the slave side is the adder/subtractor.
interface addsub_multicycle_if #(
  parameter int W = 15
);
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         v;
  logic         cout;

  modport master (output start, sub, a, b, input busy, done, s, v, cout);
  modport slave  (input start, sub, a, b, output busy, done, s, v, cout);
endinterface

// File: rtl/addsub_multicycle.sv
// W-bit two's-complement add/sub processing K bits per clock, LSB first; result after W/K+1 cycles.
// Optional saturation on signed overflow when ADDSUB_SATURATE_EN is defined; START during RUN is ignored.
module addsub_multicycle #(
  parameter int W = 15,
  parameter int K = 3
) (
  input  logic               clk,
  input  logic               rst,
  addsub_multicycle_if.slave bus
);
  localparam int N  = W / K;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  s_r;
  logic [IW-1:0] idx;
  logic          carry;
  logic          busy_r;
  logic          done_r;
  logic          v_r;
  logic          cout_r;
  logic [K:0]    sum;
  logic          ovf;
  logic          last;

  always_comb begin
    sum  = {1'b0, a_r[idx*K +: K]} + {1'b0, b_r[idx*K +: K]} + {{K{1'b0}}, carry};
    // Carry into the sign bit recovered from the sum bit; only meaningful on the last chunk.
    ovf  = a_r[W-1] ^ b_r[W-1] ^ sum[K-1] ^ sum[K];
    last = (idx == IW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      v_r    <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          s_r[idx*K +: K] <= sum[K-1:0];
          carry           <= sum[K];
          idx             <= idx + IW'(1);
          if (last) begin
            v_r    <= ovf;
            cout_r <= sum[K];
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_DONE;
`ifdef ADDSUB_SATURATE_EN
            if (ovf) s_r <= a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation, giving back-to-back issue.
          done_r <= 1'b0;
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= ST_RUN;
          end else begin
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.v    = v_r;
  assign bus.cout = cout_r;
endmodule
